// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU.
// Holds the op codes, the FSM states and the long-op classifier.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_MUL  = 4'b1010;
    localparam logic [3:0] ALU_DIVU = 4'b1100;
    localparam logic [3:0] ALU_REMU = 4'b1101;

    typedef enum logic [3:0] {
        OP_ADD  = ALU_ADD,
        OP_SUB  = ALU_SUB,
        OP_AND  = ALU_AND,
        OP_OR   = ALU_OR,
        OP_XOR  = ALU_XOR,
        OP_SLT  = ALU_SLT,
        OP_SLTU = ALU_SLTU,
        OP_SLL  = ALU_SLL,
        OP_SRL  = ALU_SRL,
        OP_SRA  = ALU_SRA,
        OP_MUL  = ALU_MUL,
        OP_DIVU = ALU_DIVU,
        OP_REMU = ALU_REMU
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    function automatic logic is_long(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative datapath: shift-add multiply and restoring unsigned divide.
// One step per cycle; done flags the final step, result is its outcome.
module alu_mc_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    logic             running;
    logic             is_mul;
    logic             want_rem;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [WIDTH-1:0] rem, quo, dvsr;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             fits;
    logic [WIDTH-1:0] acc_n, rem_n, quo_n;

    // A zero divisor always "fits", giving all-ones quotient and
    // leaving the dividend shifted wholly into the remainder.
    always_comb begin
        trial = {rem, quo[WIDTH-1]};
        diff  = trial - {1'b0, dvsr};
        fits  = trial >= {1'b0, dvsr};
        acc_n = mplier[0] ? acc + mcand : acc;
        rem_n = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_n = {quo[WIDTH-2:0], fits};
    end

    assign done   = running && (cnt == CNT_W'(WIDTH - 1));
    assign result = is_mul ? acc_n : (want_rem ? rem_n : quo_n);

    always_ff @(posedge clk) begin
        if (rst) begin
            running  <= 1'b0;
            is_mul   <= 1'b0;
            want_rem <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rem      <= '0;
            quo      <= '0;
            dvsr     <= '0;
        end else if (start) begin
            running  <= 1'b1;
            is_mul   <= (op == ALU_MUL);
            want_rem <= (op == ALU_REMU);
            cnt      <= '0;
            acc      <= '0;
            mcand    <= a;
            mplier   <= b;
            rem      <= '0;
            quo      <= a;
            dvsr     <= b;
        end else if (running) begin
            acc    <= acc_n;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            rem    <= rem_n;
            quo    <= quo_n;
            cnt    <= cnt + CNT_W'(1);
            if (done)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU for the execute stage with valid/ready on both sides.
// Short ops finish in one cycle; MUL/DIVU/REMU run in alu_mc_iter.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ALUop1,
    input  logic [WIDTH-1:0] ALUop2,
    input  logic [3:0]       ALUctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUout,
    output logic             EQ,
    output logic             busy
);

    localparam int SH_W = $clog2(WIDTH);

    state_t           state;
    logic             accept;
    logic [SH_W-1:0]  sh;
    logic [WIDTH-1:0] single;
    logic             iter_done;
    logic [WIDTH-1:0] iter_result;

    assign sh        = ALUop2[SH_W-1:0];
    assign in_ready  = (state == S_IDLE) || ((state == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_BUSY);

    always_comb begin
        single = '0;
        case (ALUctrl)
            ALU_ADD:  single = ALUop1 + ALUop2;
            ALU_SUB:  single = ALUop1 - ALUop2;
            ALU_AND:  single = ALUop1 & ALUop2;
            ALU_OR:   single = ALUop1 | ALUop2;
            ALU_XOR:  single = ALUop1 ^ ALUop2;
            ALU_SLT:  single = {{(WIDTH-1){1'b0}}, $signed(ALUop1) < $signed(ALUop2)};
            ALU_SLTU: single = {{(WIDTH-1){1'b0}}, ALUop1 < ALUop2};
            ALU_SLL:  single = ALUop1 << sh;
            ALU_SRL:  single = ALUop1 >> sh;
            ALU_SRA:  single = WIDTH'($signed(ALUop1) >>> sh);
            default:  single = '0;
        endcase
    end

    alu_mc_iter #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_iter (
        .clk   (clk),
        .rst   (rst),
        .start (accept && is_long(ALUctrl)),
        .op    (ALUctrl),
        .a     (ALUop1),
        .b     (ALUop2),
        .done  (iter_done),
        .result(iter_result)
    );

    // DONE with out_ready behaves like IDLE, so both share one arm.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            ALUout <= '0;
            EQ     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        EQ <= (ALUop1 == ALUop2);
                        if (is_long(ALUctrl)) begin
                            state <= S_BUSY;
                        end else begin
                            ALUout <= single;
                            state  <= S_DONE;
                        end
                    end else if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (iter_done) begin
                        ALUout <= iter_result;
                        state  <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
